// File: rtl/countdown_ctrl_if.sv
// countdown_ctrl_if: pulse inputs and display-facing outputs of the countdown
// timer controller. The master side drives the one-cycle pulses. The slave
// side (the controller) drives the count and the status flags.
interface countdown_ctrl_if #(
  parameter int DIGITS = 2
);
  localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                  tick;
  logic                  pb_start;
  logic                  pb_restart;
  logic                  pb_set;
  logic                  pb_digit;
  logic                  pb_inc;
  logic [4*DIGITS-1:0]   q;
  logic                  is_pause;
  logic                  is_restart;
  logic                  is_setting;
  logic [SEL_W-1:0]      sel_digit;

  modport master (
    output tick, pb_start, pb_restart, pb_set, pb_digit, pb_inc,
    input  q, is_pause, is_restart, is_setting, sel_digit
  );

  modport slave (
    input  tick, pb_start, pb_restart, pb_set, pb_digit, pb_inc,
    output q, is_pause, is_restart, is_setting, sel_digit
  );
endinterface

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: BCD countdown timer controller feeding the LED and 7-segment
// stages. It holds a programmable preset and counts down once per tick. All
// outputs are registered and change on the edge after the input pulse.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN. When it is defined, a tick
// in DONE reloads the preset and resumes counting, which makes a periodic timer.
module countdown_ctrl #(
  parameter int                  DIGITS = 2,
  parameter logic [4*DIGITS-1:0] PRESET = 'h30
) (
  input  logic              clk,
  input  logic              rst,
  countdown_ctrl_if.slave   bus
);
  localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE,
    S_SETTING
  } state_t;

  state_t              r_state;
  logic [4*DIGITS-1:0] r_q;
  logic [4*DIGITS-1:0] r_preset;
  logic [SEL_W-1:0]    r_sel;
  logic                r_is_pause;
  logic                r_is_restart;
  logic                r_is_setting;

  state_t              w_state_nxt;
  logic [4*DIGITS-1:0] w_q_nxt;
  logic [4*DIGITS-1:0] w_preset_nxt;
  logic [SEL_W-1:0]    w_sel_nxt;

  // BCD decrement by one, borrowing across digits (e.g. 10 -> 09).
  function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
    logic       borrow;
    logic [3:0] d;
    bcd_dec = v;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          d = 4'd9;
        end else begin
          d      = d - 4'd1;
          borrow = 1'b0;
        end
      end
      bcd_dec[4*i +: 4] = d;
    end
  endfunction

  // Next-state logic. Events are checked in priority order, and the first one
  // that applies in the current state wins for that cycle.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one
    // unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_preset_nxt = r_preset;
    w_sel_nxt    = r_sel;
    case (r_state)
      S_IDLE: begin
        if (bus.pb_set) begin
          w_state_nxt = S_SETTING;
        end else if (bus.pb_start) begin
          w_state_nxt = (r_preset == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.pb_restart) begin
          w_state_nxt = S_IDLE;
        end else if (bus.pb_start) begin
          w_state_nxt = S_PAUSE;
        end else if (bus.tick) begin
          w_q_nxt = bcd_dec(r_q);
          if (w_q_nxt == '0) w_state_nxt = S_DONE;
        end
      end
      S_PAUSE: begin
        if (bus.pb_restart) begin
          w_state_nxt = S_IDLE;
        end else if (bus.pb_start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.pb_restart) begin
          w_state_nxt = S_IDLE;
        end
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        else if (bus.tick && (r_preset != '0)) begin
          w_state_nxt = S_RUN;
          w_q_nxt     = r_preset;
        end
`endif
      end
      S_SETTING: begin
        if (bus.pb_set) begin
          w_state_nxt = S_IDLE;
          w_sel_nxt   = '0;
        end else if (bus.pb_digit) begin
          w_sel_nxt = (r_sel == SEL_W'(DIGITS - 1)) ? '0 : r_sel + 1'b1;
        end else if (bus.pb_inc) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (i == int'(r_sel)) begin
              w_preset_nxt[4*i +: 4] = (r_preset[4*i +: 4] >= 4'd9) ? 4'd0
                                     : r_preset[4*i +: 4] + 4'd1;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // In IDLE and SETTING the count always shows the preset.
    if (w_state_nxt == S_IDLE || w_state_nxt == S_SETTING) w_q_nxt = w_preset_nxt;
  end

  // State, count, preset and registered status flags.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every register
    // samples the pre-edge values and ordering inside the block cannot matter.
    if (rst) begin
      r_state      <= S_IDLE;
      r_q          <= PRESET;
      r_preset     <= PRESET;
      r_sel        <= '0;
      r_is_pause   <= 1'b1;
      r_is_restart <= 1'b0;
      r_is_setting <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_q          <= w_q_nxt;
      r_preset     <= w_preset_nxt;
      r_sel        <= w_sel_nxt;
      r_is_pause   <= (w_state_nxt != S_RUN);
      r_is_restart <= (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE) ||
                      (w_state_nxt == S_DONE);
      r_is_setting <= (w_state_nxt == S_SETTING);
    end
  end

  assign bus.q          = r_q;
  assign bus.is_pause   = r_is_pause;
  assign bus.is_restart = r_is_restart;
  assign bus.is_setting = r_is_setting;
  assign bus.sel_digit  = r_sel;
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: directed scenarios plus a randomized run. The randomized
// run checks the controller against a decimal-arithmetic reference model.
module tb_countdown_ctrl;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  countdown_ctrl_if #(.DIGITS(D)) bus_if ();

  countdown_ctrl #(.DIGITS(D), .PRESET(8'h30)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Reference model: count kept as a plain integer, preset as decimal digits.
  typedef enum {MD_IDLE, MD_RUN, MD_HOLD, MD_END, MD_EDIT} md_t;
  md_t m_mode;
  int  m_count;
  int  m_pre [D];
  int  m_sel;

  function automatic int pre_val();
    int v = 0;
    int w = 1;
    for (int i = 0; i < D; i++) begin
      v += m_pre[i] * w;
      w *= 10;
    end
    return v;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input int n);
    logic [4*D-1:0] r;
    int             v;
    r = '0;
    v = n;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_step(input bit r, t, st, rs, se, dg, inc);
    if (r) begin
      m_mode = MD_IDLE; m_pre[0] = 0; m_pre[1] = 3; m_sel = 0; m_count = 30;
    end else begin
      case (m_mode)
        MD_IDLE:
          if (se) m_mode = MD_EDIT;
          else if (st) begin
            m_count = pre_val();
            m_mode  = (m_count == 0) ? MD_END : MD_RUN;
          end
        MD_RUN:
          if (rs) m_mode = MD_IDLE;
          else if (st) m_mode = MD_HOLD;
          else if (t) begin
            m_count--;
            if (m_count == 0) m_mode = MD_END;
          end
        MD_HOLD:
          if (rs) m_mode = MD_IDLE;
          else if (st) m_mode = MD_RUN;
        MD_END:
          if (rs) m_mode = MD_IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          else if (t && pre_val() != 0) begin
            m_mode = MD_RUN; m_count = pre_val();
          end
`endif
        MD_EDIT:
          if (se) begin m_mode = MD_IDLE; m_sel = 0; end
          else if (dg) m_sel = (m_sel + 1) % D;
          else if (inc) m_pre[m_sel] = (m_pre[m_sel] + 1) % 10;
        default: m_mode = MD_IDLE;
      endcase
    end
  endtask

  // One clock: drive pulses, let the edge take them, then sample 1 time unit later.
  task automatic cycle(input bit r, t, st, rs, se, dg, inc);
    rst = r; bus_if.tick = t; bus_if.pb_start = st; bus_if.pb_restart = rs;
    bus_if.pb_set = se; bus_if.pb_digit = dg; bus_if.pb_inc = inc;
    @(posedge clk);
    #1;
    rst = 0; bus_if.tick = 0; bus_if.pb_start = 0; bus_if.pb_restart = 0;
    bus_if.pb_set = 0; bus_if.pb_digit = 0; bus_if.pb_inc = 0;
    model_step(r, t, st, rs, se, dg, inc);
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({bus_if.q, bus_if.is_pause, bus_if.is_restart, bus_if.is_setting, bus_if.sel_digit}
        !== {8'h30, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: q=%h p=%b r=%b s=%b sel=%0d, want q=30 p=1 r=0 s=0 sel=0",
               bus_if.q, bus_if.is_pause, bus_if.is_restart, bus_if.is_setting, bus_if.sel_digit);
    end
  endtask

  task automatic test_full_countdown();
    cycle(0, 0, 1, 0, 0, 0, 0);
    n_tests++;
    if (bus_if.q !== 8'h30 || bus_if.is_pause !== 1'b0 || bus_if.is_restart !== 1'b1) begin
      n_fail++;
      $display("FAIL start: q=%h p=%b r=%b, want q=30 p=0 r=1", bus_if.q, bus_if.is_pause, bus_if.is_restart);
    end
    for (int k = 1; k <= 30; k++) begin
      cycle(0, 1, 0, 0, 0, 0, 0);
      n_tests++;
      if (bus_if.q !== to_bcd(30 - k) || bus_if.is_pause !== (k == 30)) begin
        n_fail++;
        $display("FAIL countdown tick %0d: q=%h p=%b, want q=%h p=%b",
                 k, bus_if.q, bus_if.is_pause, to_bcd(30 - k), (k == 30));
      end
    end
    cycle(0, 1, 0, 0, 0, 0, 0);
    n_tests++;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    if (bus_if.q !== 8'h30 || bus_if.is_pause !== 1'b0 || bus_if.is_restart !== 1'b1) begin
      n_fail++;
      $display("FAIL tick31: q=%h p=%b r=%b, want q=30 p=0 r=1", bus_if.q, bus_if.is_pause, bus_if.is_restart);
    end
`else
    if (bus_if.q !== 8'h00 || bus_if.is_pause !== 1'b1 || bus_if.is_restart !== 1'b1) begin
      n_fail++;
      $display("FAIL tick31: q=%h p=%b r=%b, want q=00 p=1 r=1", bus_if.q, bus_if.is_pause, bus_if.is_restart);
    end
`endif
  endtask

  task automatic test_pause();
    cycle(0, 0, 0, 1, 0, 0, 0);                 // back to IDLE, q=30
    cycle(0, 0, 1, 0, 0, 0, 0);                 // RUN
    for (int k = 0; k < 5; k++) cycle(0, 1, 0, 0, 0, 0, 0);
    n_tests++;
    if (bus_if.q !== 8'h25) begin
      n_fail++; $display("FAIL pause_setup: q=%h want 25", bus_if.q);
    end
    cycle(0, 1, 1, 0, 0, 0, 0);                 // pb_start wins over tick
    n_tests++;
    if (bus_if.q !== 8'h25 || bus_if.is_pause !== 1'b1 || bus_if.is_restart !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_same_cycle: q=%h p=%b r=%b, want q=25 p=1 r=1", bus_if.q, bus_if.is_pause, bus_if.is_restart);
    end
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 0, 0, 0);
    n_tests++;
    if (bus_if.q !== 8'h25) begin
      n_fail++; $display("FAIL pause_hold: q=%h want 25", bus_if.q);
    end
    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    n_tests++;
    if (bus_if.q !== 8'h24 || bus_if.is_pause !== 1'b0) begin
      n_fail++; $display("FAIL resume: q=%h p=%b, want q=24 p=0", bus_if.q, bus_if.is_pause);
    end
  endtask

  task automatic test_restart();
    for (int k = 0; k < 7; k++) cycle(0, 1, 0, 0, 0, 0, 0);
    n_tests++;
    if (bus_if.q !== 8'h17) begin
      n_fail++; $display("FAIL restart_setup: q=%h want 17", bus_if.q);
    end
    cycle(0, 0, 0, 1, 0, 0, 0);
    n_tests++;
    if (bus_if.q !== 8'h30 || bus_if.is_restart !== 1'b0 || bus_if.is_pause !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_run: q=%h r=%b p=%b, want q=30 r=0 p=1", bus_if.q, bus_if.is_restart, bus_if.is_pause);
    end
    cycle(0, 0, 1, 0, 0, 0, 0);                 // RUN
    cycle(0, 1, 0, 0, 0, 0, 0);                 // 29
    cycle(0, 0, 1, 0, 0, 0, 0);                 // PAUSE
    cycle(0, 0, 1, 1, 0, 0, 0);                 // restart beats start
    n_tests++;
    if (bus_if.q !== 8'h30 || bus_if.is_restart !== 1'b0 || bus_if.is_pause !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_pause: q=%h r=%b p=%b, want q=30 r=0 p=1", bus_if.q, bus_if.is_restart, bus_if.is_pause);
    end
  endtask

  task automatic test_setting();
    cycle(0, 0, 0, 0, 1, 0, 0);
    n_tests++;
    if (bus_if.is_setting !== 1'b1 || bus_if.q !== 8'h30 || bus_if.sel_digit !== 1'b0) begin
      n_fail++;
      $display("FAIL set_enter: s=%b q=%h sel=%0d, want s=1 q=30 sel=0", bus_if.is_setting, bus_if.q, bus_if.sel_digit);
    end
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1, 0);
    n_tests++;
    if (bus_if.q !== 8'h33 || bus_if.sel_digit !== 1'b1) begin
      n_fail++; $display("FAIL set_digit0: q=%h sel=%0d, want q=33 sel=1", bus_if.q, bus_if.sel_digit);
    end
    for (int k = 0; k < 6; k++) cycle(0, 0, 0, 0, 0, 0, 1);
    n_tests++;
    if (bus_if.q !== 8'h93) begin
      n_fail++; $display("FAIL set_nine: q=%h want 93", bus_if.q);
    end
    cycle(0, 0, 0, 0, 0, 0, 1);
    n_tests++;
    if (bus_if.q !== 8'h03) begin
      n_fail++; $display("FAIL set_wrap: q=%h want 03", bus_if.q);
    end
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 0, 0);
    n_tests++;
    if (bus_if.q !== 8'h53 || bus_if.is_setting !== 1'b0 || bus_if.sel_digit !== 1'b0 ||
        bus_if.is_pause !== 1'b1 || bus_if.is_restart !== 1'b0) begin
      n_fail++;
      $display("FAIL set_exit: q=%h s=%b sel=%0d p=%b r=%b, want q=53 s=0 sel=0 p=1 r=0",
               bus_if.q, bus_if.is_setting, bus_if.sel_digit, bus_if.is_pause, bus_if.is_restart);
    end
    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    n_tests++;
    if (bus_if.q !== 8'h52) begin
      n_fail++; $display("FAIL new_preset_run: q=%h want 52", bus_if.q);
    end
  endtask

  task automatic test_auto_reload();
    logic [7:0] exp_q [3];
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 2; k++) cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 7; k++) cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 0, 0);
    n_tests++;
    if (bus_if.q !== 8'h02) begin
      n_fail++; $display("FAIL reload_preset: q=%h want 02", bus_if.q);
    end
    exp_q[0] = 8'h01;
    exp_q[1] = 8'h00;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    exp_q[2] = 8'h02;
`else
    exp_q[2] = 8'h00;
`endif
    cycle(0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 0, 0, 0, 0);
      n_tests++;
      if (bus_if.q !== exp_q[k]) begin
        n_fail++; $display("FAIL reload_tick%0d: q=%h want %h", k + 1, bus_if.q, exp_q[k]);
      end
    end
    n_tests++;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    if (bus_if.is_pause !== 1'b0 || bus_if.is_restart !== 1'b1) begin
`else
    if (bus_if.is_pause !== 1'b1 || bus_if.is_restart !== 1'b1) begin
`endif
      n_fail++; $display("FAIL reload_flags: p=%b r=%b", bus_if.is_pause, bus_if.is_restart);
    end
  endtask

  task automatic test_random();
    logic [12:0] got, exp;
    int          shown = 0;
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      cycle(($urandom_range(499) == 0), ($urandom_range(1) == 0),
            ($urandom_range(7) == 0), ($urandom_range(39) == 0),
            ($urandom_range(29) == 0), ($urandom_range(9) == 0),
            ($urandom_range(5) == 0));
      exp = {((m_mode == MD_IDLE || m_mode == MD_EDIT) ? to_bcd(pre_val()) : to_bcd(m_count)),
             (m_mode != MD_RUN), (m_mode inside {MD_RUN, MD_HOLD, MD_END}),
             (m_mode == MD_EDIT), 1'(m_sel)};
      got = {bus_if.q, bus_if.is_pause, bus_if.is_restart, bus_if.is_setting, bus_if.sel_digit};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random cycle %0d: {q,p,r,s,sel}=%h want %h", n, got, exp);
        end
      end
    end
  endtask

  initial begin
    bus_if.tick = 0; bus_if.pb_start = 0; bus_if.pb_restart = 0;
    bus_if.pb_set = 0; bus_if.pb_digit = 0; bus_if.pb_inc = 0;
    model_step(1, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_full_countdown();
    test_pause();
    test_restart();
    test_setting();
    test_auto_reload();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
